// File: rtl/wam_ctl_pkg.sv
// Shared types and constants for the whac-a-mole round scheduler.
// State encodings, the LFSR tap mask and the default timing values.
package wam_ctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PICK = 3'd1,
        ST_SHOW = 3'd2,
        ST_GAP  = 3'd3,
        ST_OVER = 3'd4
    } state_t;

    // Taps 8,6,5,4 of a left-shifting Fibonacci LFSR (bits 7,5,4,3).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int         DEF_SHOW_INIT = 16;
    localparam int         DEF_SHOW_MIN  = 4;
    localparam int         DEF_SHOW_STEP = 2;
    localparam int         DEF_LVL_HITS  = 8;
    localparam int         DEF_GAP_TICKS = 4;
    localparam int         DEF_ROUNDS    = 32;
    localparam logic [7:0] DEF_SEED      = 8'hA5;

    // Shrink the show window by one step, never going below the floor.
    function automatic logic [4:0] shrink_show(input logic [4:0] cur,
                                               input logic [4:0] step,
                                               input logic [4:0] floor_v);
        logic [5:0] lim;
        lim = {1'b0, floor_v} + {1'b0, step};
        if ({1'b0, cur} >= lim) return cur - step;
        return floor_v;
    endfunction

endpackage

// File: rtl/wam_ctl_if.sv
// Signal bundle between the time base / tap logic and the round scheduler.
// There is no valid/ready handshake: start is a level, tick and hit are one-cycle strobes, and every output is a register whose pulses last exactly one clock.
interface wam_ctl_if;
    import wam_ctl_pkg::*;

    logic       start;
    logic       tick;
    logic [7:0] hit;
    logic [7:0] mole;
    logic       hit_p;
    logic       miss_p;
    logic       wrong_p;
    logic [5:0] round;
    logic [2:0] level;
    logic       busy;
    logic       game_over;
    state_t     state;
    logic [7:0] lfsr;

    modport master (
        output start, tick, hit,
        input  mole, hit_p, miss_p, wrong_p, round, level, busy, game_over, state, lfsr
    );

    modport slave (
        input  start, tick, hit,
        output mole, hit_p, miss_p, wrong_p, round, level, busy, game_over, state, lfsr
    );

endinterface

// File: rtl/wam_lfsr.sv
// 8-bit Fibonacci LFSR with enable; also used by the LED pattern logic.
// Seed must be non-zero or the register locks up at zero.
module wam_lfsr
    import wam_ctl_pkg::*;
#(
    parameter logic [7:0] SEED = DEF_SEED
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       en,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[6:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/wam_ctl.sv
// Whac-a-mole round scheduler: picks a hole, times the show window, reports
// hit/miss/wrong events and tightens the window as the hit count rises.
module wam_ctl
    import wam_ctl_pkg::*;
#(
    parameter int         NHOLE     = 8,
    parameter int         SHOW_INIT = DEF_SHOW_INIT,
    parameter int         SHOW_MIN  = DEF_SHOW_MIN,
    parameter int         SHOW_STEP = DEF_SHOW_STEP,
    parameter int         LVL_HITS  = DEF_LVL_HITS,
    parameter int         GAP_TICKS = DEF_GAP_TICKS,
    parameter int         ROUNDS    = DEF_ROUNDS,
    parameter logic [7:0] SEED      = DEF_SEED
) (
    input  logic     clk,
    input  logic     clr_n,
    wam_ctl_if.slave bus
);

    state_t           state_q, state_d;
    logic [NHOLE-1:0] mole_q, mole_d;
    logic [4:0]       tcnt_q, tcnt_d;
    logic [4:0]       show_q, show_d;
    logic [5:0]       round_q, round_d;
    logic [2:0]       level_q, level_d;
    logic [2:0]       prev_q, prev_d;
    logic [3:0]       hcnt_q, hcnt_d;
    logic             hit_p_q, hit_p_d;
    logic             miss_p_q, miss_p_d;
    logic             wrong_p_q, wrong_p_d;
    logic             busy_q, over_q;
    logic             lfsr_en;
    logic [7:0]       lfsr;
    logic [2:0]       cand, hole;

    wam_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .clr_n (clr_n),
        .en    (lfsr_en),
        .q     (lfsr)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            mole_q    <= '0;
            tcnt_q    <= '0;
            show_q    <= 5'(SHOW_INIT);
            round_q   <= '0;
            level_q   <= '0;
            prev_q    <= '0;
            hcnt_q    <= '0;
            hit_p_q   <= 1'b0;
            miss_p_q  <= 1'b0;
            wrong_p_q <= 1'b0;
            busy_q    <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mole_q    <= mole_d;
            tcnt_q    <= tcnt_d;
            show_q    <= show_d;
            round_q   <= round_d;
            level_q   <= level_d;
            prev_q    <= prev_d;
            hcnt_q    <= hcnt_d;
            hit_p_q   <= hit_p_d;
            miss_p_q  <= miss_p_d;
            wrong_p_q <= wrong_p_d;
            busy_q    <= (state_d == ST_PICK) || (state_d == ST_SHOW) || (state_d == ST_GAP);
            over_q    <= (state_d == ST_OVER);
        end
    end

    always_comb begin
        state_d   = state_q;
        mole_d    = mole_q;
        tcnt_d    = tcnt_q;
        show_d    = show_q;
        round_d   = round_q;
        level_d   = level_q;
        prev_d    = prev_q;
        hcnt_d    = hcnt_q;
        hit_p_d   = 1'b0;
        miss_p_d  = 1'b0;
        wrong_p_d = 1'b0;
        lfsr_en   = 1'b0;
        // The LFSR advances on entry to PICK, so here it already holds the new value.
        cand      = lfsr[2:0];
        hole      = (cand == prev_q) ? cand + 3'd1 : cand;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                mole_d = '0;
                if (bus.start) begin
                    state_d = ST_PICK;
                    round_d = '0;
                    level_d = '0;
                    hcnt_d  = '0;
                    show_d  = 5'(SHOW_INIT);
                    lfsr_en = 1'b1;
                end
            end
            ST_PICK: begin
                mole_d  = NHOLE'(1) << hole;
                prev_d  = hole;
                tcnt_d  = show_q;
                state_d = ST_SHOW;
            end
            ST_SHOW: begin
                // prev_q is the hole currently shown.
                if (bus.hit[prev_q]) begin
                    hit_p_d = 1'b1;
                    mole_d  = '0;
                    tcnt_d  = 5'(GAP_TICKS);
                    state_d = ST_GAP;
                    if (hcnt_q == 4'(LVL_HITS - 1)) begin
                        hcnt_d = '0;
                        if (level_q != 3'd7) level_d = level_q + 3'd1;
                        show_d = shrink_show(show_q, 5'(SHOW_STEP), 5'(SHOW_MIN));
                    end else begin
                        hcnt_d = hcnt_q + 4'd1;
                    end
                end else if (|bus.hit) begin
                    wrong_p_d = 1'b1;
                end else if (bus.tick) begin
                    if (tcnt_q <= 5'd1) begin
                        miss_p_d = 1'b1;
                        mole_d   = '0;
                        tcnt_d   = 5'(GAP_TICKS);
                        state_d  = ST_GAP;
                    end else begin
                        tcnt_d = tcnt_q - 5'd1;
                    end
                end
            end
            ST_GAP: begin
                mole_d = '0;
                if (bus.tick) begin
                    if (tcnt_q <= 5'd1) begin
                        round_d = round_q + 6'd1;
                        if (round_q + 6'd1 == 6'(ROUNDS)) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_PICK;
                            lfsr_en = 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q - 5'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                mole_d  = '0;
            end
        endcase
    end

    assign bus.mole      = mole_q;
    assign bus.hit_p     = hit_p_q;
    assign bus.miss_p    = miss_p_q;
    assign bus.wrong_p   = wrong_p_q;
    assign bus.round     = round_q;
    assign bus.level     = level_q;
    assign bus.busy      = busy_q;
    assign bus.game_over = over_q;
    assign bus.state     = state_q;
    assign bus.lfsr      = lfsr;

endmodule

// File: tb/tb_wam_ctl.sv
// Randomised bench for wam_ctl: a game-level model predicts every event,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_wam_ctl;
    import wam_ctl_pkg::*;

    localparam int         SHOW_INIT = 16;
    localparam int         SHOW_MIN  = 4;
    localparam int         SHOW_STEP = 2;
    localparam int         LVL_HITS  = 4;
    localparam int         GAP_TICKS = 4;
    localparam int         ROUNDS    = 32;
    localparam logic [7:0] SEED      = 8'hA5;
    localparam int         NGAMES    = 32;

    localparam int K_WRONG = 1;
    localparam int K_HIT   = 2;
    localparam int K_MISS  = 3;
    localparam int K_MOLE  = 4;
    localparam int K_OVER  = 5;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    wam_ctl_if bus ();

    wam_ctl #(
        .NHOLE     (8),
        .SHOW_INIT (SHOW_INIT),
        .SHOW_MIN  (SHOW_MIN),
        .SHOW_STEP (SHOW_STEP),
        .LVL_HITS  (LVL_HITS),
        .GAP_TICKS (GAP_TICKS),
        .ROUNDS    (ROUNDS),
        .SEED      (SEED)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    logic [15:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    bit abort  = 1'b0;

    // Game-level model of the scheduler.
    int lfsr_m, prev_m, hole_m, round_m, level_m, hcnt_m, show_m;

    function automatic logic [15:0] mk_ev(int kind, int rnd, int lvl, int hole);
        mk_ev = {kind[3:0], rnd[5:0], lvl[2:0], hole[2:0]};
    endfunction

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic check_ev(input string name, input logic [15:0] got);
        logic [15:0] want;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event %h, none expected", name, got);
        end else begin
            want = exp_q.pop_front();
            if (want !== got) begin
                errors++;
                $display("FAIL %s: got event %h, expected %h", name, got, want);
            end
        end
    endtask

    task automatic drain(input string where);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d events still pending, expected 0", where, exp_q.size());
            exp_q.delete();
        end
    endtask

    // One clock of stimulus, driven just after the active edge.
    task automatic cyc(input bit t, input logic [7:0] h, input bit s);
        bus.tick  = t;
        bus.hit   = h;
        bus.start = s;
        @(posedge clk);
        #1;
        bus.tick  = 1'b0;
        bus.hit   = 8'h00;
        bus.start = 1'b0;
    endtask

    task automatic pick_push();
        int fb, cand;
        fb     = ((lfsr_m >> 7) ^ (lfsr_m >> 5) ^ (lfsr_m >> 4) ^ (lfsr_m >> 3)) & 1;
        lfsr_m = ((lfsr_m << 1) | fb) & 255;
        cand   = lfsr_m % 8;
        hole_m = (cand == prev_m) ? (cand + 1) % 8 : cand;
        prev_m = hole_m;
        exp_q.push_back(mk_ev(K_MOLE, round_m, level_m, hole_m));
    endtask

    task automatic wait_for(input string name, input bit want_over);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            cyc(1'b0, 8'h00, 1'b0);
            ok = want_over ? bus.game_over : (bus.mole != 8'h00);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: not seen within 8 cycles, expected it", name);
            abort = 1'b1;
        end
    endtask

    task automatic maybe_wrong(input int mask);
        logic [7:0] w;
        if ($urandom_range(0, 3) == 0) begin
            w = 8'($urandom_range(1, 255)) & ~8'(mask);
            if (w != 8'h00) begin
                exp_q.push_back(mk_ev(K_WRONG, 0, 0, 0));
                cyc(1'b0, w, 1'b0);
            end
        end
    endtask

    // Idle cycles inside the show window; start is strobed to prove it is ignored.
    task automatic show_idle();
        repeat ($urandom_range(0, 1)) cyc(1'b0, 8'h00, 1'($urandom_range(0, 1)));
    endtask

    task automatic play_round(input bit miss);
        int mask, k;
        bit t;
        logic [7:0] w;
        mask = 1 << hole_m;
        wait_for("mole_shown", 1'b0);
        if (abort) return;
        if (!miss) begin
            k = ($urandom_range(0, 7) == 0) ? show_m - 1 : $urandom_range(0, 3);
            for (int i = 0; i < k; i++) begin
                maybe_wrong(mask);
                cyc(1'b1, 8'h00, 1'b0);
                show_idle();
            end
            maybe_wrong(mask);
            // On the last tick of the window the hit must still beat the timeout.
            t = (k == show_m - 1) ? 1'b1 : 1'($urandom_range(0, 1));
            w = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            exp_q.push_back(mk_ev(K_HIT, 0, 0, 0));
            cyc(t, w | 8'(mask), 1'b0);
            hcnt_m++;
            if (hcnt_m == LVL_HITS) begin
                hcnt_m = 0;
                if (level_m < 7) level_m++;
                show_m = (show_m - SHOW_STEP < SHOW_MIN) ? SHOW_MIN : show_m - SHOW_STEP;
            end
        end else begin
            for (int i = 0; i < show_m; i++) begin
                maybe_wrong(mask);
                if (i == show_m - 1) exp_q.push_back(mk_ev(K_MISS, 0, 0, 0));
                cyc(1'b1, 8'h00, 1'b0);
                show_idle();
            end
        end
        for (int g = 0; g < GAP_TICKS; g++) begin
            if (g == GAP_TICKS - 1) begin
                drain("round");
                round_m++;
                if (round_m == ROUNDS) exp_q.push_back(mk_ev(K_OVER, round_m, level_m, 0));
                else pick_push();
            end
            cyc(1'b1, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 1'b0);
            if (g != GAP_TICKS - 1) repeat ($urandom_range(0, 1)) cyc(1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic play_game(input int gidx);
        bit miss;
        round_m = 0;
        level_m = 0;
        hcnt_m  = 0;
        show_m  = SHOW_INIT;
        pick_push();
        cyc(1'b0, 8'h00, 1'b1);
        for (int r = 0; r < ROUNDS && !abort; r++) begin
            if (gidx == 0) miss = 1'b0;
            else if (gidx == 1) miss = (r >= 28);
            else miss = ($urandom_range(0, 7) == 0);
            play_round(miss);
        end
        if (abort) return;
        wait_for("game_over", 1'b1);
        if (abort) return;
        check_val("over_round", int'(bus.round), ROUNDS);
        check_val("over_busy", int'(bus.busy), 0);
        check_val("over_state", int'(bus.state), int'(ST_OVER));
        repeat (4) cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
        drain("over");
        check_val("over_level_held", int'(bus.level), level_m);
    endtask

    // Monitor: every DUT event is matched against the head of the queue.
    initial begin
        logic [7:0] prev_mole;
        bit         prev_over;
        int         last_hole, idx;
        prev_mole = 8'h00;
        prev_over = 1'b0;
        last_hole = 0;
        forever begin
            @(negedge clk);
            if (!clr_n) begin
                prev_mole = 8'h00;
                prev_over = 1'b0;
                last_hole = 0;
            end else begin
                if (bus.wrong_p) check_ev("wrong_p", mk_ev(K_WRONG, 0, 0, 0));
                if (bus.hit_p)   check_ev("hit_p", mk_ev(K_HIT, 0, 0, 0));
                if (bus.miss_p)  check_ev("miss_p", mk_ev(K_MISS, 0, 0, 0));
                if (bus.mole != 8'h00 && prev_mole == 8'h00) begin
                    idx = 0;
                    for (int i = 0; i < 8; i++) if (bus.mole[i]) idx = i;
                    check_val("mole_onehot", int'($onehot(bus.mole)), 1);
                    checks++;
                    if (idx == last_hole) begin
                        errors++;
                        $display("FAIL repeat_hole: got hole %0d again, expected a different hole", idx);
                    end
                    last_hole = idx;
                    check_ev("mole", mk_ev(K_MOLE, int'(bus.round), int'(bus.level), idx));
                end
                if (bus.game_over && !prev_over) begin
                    check_val("over_busy_low", int'(bus.busy), 0);
                    check_ev("game_over", mk_ev(K_OVER, int'(bus.round), int'(bus.level), 0));
                end
                prev_mole = bus.mole;
                prev_over = bus.game_over;
            end
        end
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        bus.start = 1'b0;
        bus.tick  = 1'b0;
        bus.hit   = 8'h00;
        lfsr_m    = int'(SEED);
        prev_m    = 0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_mole", int'(bus.mole), 0);
        check_val("rst_round", int'(bus.round), 0);
        check_val("rst_level", int'(bus.level), 0);
        check_val("rst_busy", int'(bus.busy), 0);
        check_val("rst_over", int'(bus.game_over), 0);
        check_val("rst_state", int'(bus.state), int'(ST_IDLE));
        check_val("rst_pulses", int'({bus.hit_p, bus.miss_p, bus.wrong_p}), 0);
        clr_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);

        // Abort a game mid-show with the asynchronous reset.
        round_m = 0;
        level_m = 0;
        hcnt_m  = 0;
        show_m  = SHOW_INIT;
        pick_push();
        cyc(1'b0, 8'h00, 1'b1);
        wait_for("first_mole", 1'b0);
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b1, 8'h00, 1'b0);
        clr_n = 1'b0;
        #1;
        check_val("midrst_mole", int'(bus.mole), 0);
        check_val("midrst_round", int'(bus.round), 0);
        check_val("midrst_level", int'(bus.level), 0);
        check_val("midrst_busy", int'(bus.busy), 0);
        check_val("midrst_state", int'(bus.state), int'(ST_IDLE));
        @(posedge clk);
        #1;
        clr_n  = 1'b1;
        lfsr_m = int'(SEED);
        prev_m = 0;
        repeat (10) cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
        drain("after_reset");
        check_val("post_rst_state", int'(bus.state), int'(ST_IDLE));
        check_val("post_rst_mole", int'(bus.mole), 0);

        for (int g = 0; g < NGAMES && !abort; g++) play_game(g);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
